exu2idu_ctrl: RTL and testbench
===============================

Name: exu2idu_ctrl

Overview:
Pipeline control block on the EXU side of the IDU→EXU boundary. It is the producer of the feedback that the ID/EX pipeline register consumes: it resolves branches and jumps from the registered EX-stage fields, raising exu2idu_branch_en and exu2idu_jump_en plus a redirect PC. It also detects load-use hazards against the instruction currently in IDU and stalls IDU/IFU for LOAD_LAT cycles. Two performance counters record stall cycles and flushes.

Parameters:
CPU_WIDTH, 32, datapath/PC width
REG_ADDR_WIDTH, 5, register index width
LOAD_LAT, 1, load-use stall cycles (legal range 1..7)
CNT_WIDTH, 32, perf counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ex_valid  in  1  EX stage holds a valid instruction (ID/EX enable, registered)
ex_pc  in  CPU_WIDTH  EX instruction PC
ex_imm  in  CPU_WIDTH  EX immediate
ex_branch  in  BRAN_WIDTH  branch type (package encoding)
ex_jump  in  JUMP_WIDTH  jump type (package encoding)
ex_rs1_val  in  CPU_WIDTH  forwarded rs1 operand
ex_rs2_val  in  CPU_WIDTH  forwarded rs2 operand
ex_mem_ren  in  1  EX instruction is a load
ex_reg_waddr  in  REG_ADDR_WIDTH  EX destination register
id_valid  in  1  IDU holds a valid decoded instruction
id_reg1_raddr  in  REG_ADDR_WIDTH  IDU rs1 index
id_reg2_raddr  in  REG_ADDR_WIDTH  IDU rs2 index
id_uses_rs1  in  1  IDU instruction reads rs1
id_uses_rs2  in  1  IDU instruction reads rs2
exu2idu_branch_en  out  1  taken branch; flush IF/ID and ID/EX
exu2idu_jump_en  out  1  jump; flush IF/ID and ID/EX
redirect_pc  out  CPU_WIDTH  new fetch PC, valid when either en is high
idu2exu_en  out  1  ID/EX load enable (id_valid gated by stall)
pipe_stall  out  1  hold PC and IF/ID register
stall_cycles  out  CNT_WIDTH  count of cycles with pipe_stall=1
flush_count  out  CNT_WIDTH  count of redirect events

Behaviour:
- Reset: FSM=RUN, stall counter=0, stall_cycles=0, flush_count=0. Combinational outputs follow from these values: pipe_stall=0 and idu2exu_en=id_valid.
- Redirect is combinational, zero latency, because the ID/EX register uses it as a synchronous clear in the same cycle:
  - exu2idu_jump_en = ex_valid & (ex_jump != JUMP_NONE).
  - exu2idu_branch_en = ex_valid & (ex_jump == JUMP_NONE) & branch condition true. Jump wins if both fields are nonzero.
- Branch conditions:
  - BEQ: equal. BNE: not equal.
  - BLT / BGE: signed compare.
  - BLTU / BGEU: unsigned compare.
  - BRAN_NONE: never taken.
- redirect_pc, all arithmetic modulo 2^CPU_WIDTH:
  - JAL and branches: ex_pc + ex_imm.
  - JALR: (ex_rs1_val + ex_imm) & ~1.
  - When no redirect: redirect_pc = 0.
- Hazard condition: ex_valid & ex_mem_ren & ex_reg_waddr != 0 & id_valid & ((id_uses_rs1 & id_reg1_raddr == ex_reg_waddr) | (id_uses_rs2 & id_reg2_raddr == ex_reg_waddr)).
- FSM states RUN and STALL:
  - RUN + hazard + no redirect: pipe_stall=1 this cycle (combinational).
    - If LOAD_LAT == 1, stay in RUN. The next cycle EX holds a bubble, so no re-detect.
    - Otherwise go to STALL with cnt = LOAD_LAT-1.
  - STALL: pipe_stall=1; cnt decrements each cycle; when cnt == 1, go to RUN. Total stall is exactly LOAD_LAT cycles.
  - A redirect in any state overrides: pipe_stall=0, FSM goes to RUN, cnt=0.
- idu2exu_en = id_valid & ~pipe_stall.
- Counters:
  - stall_cycles increments on every clk edge with pipe_stall=1.
  - flush_count increments on every edge with (branch_en | jump_en).
  - Both saturate at all-ones and never wrap.
- Reset mid-STALL: asynchronous return to RUN; pipe_stall drops immediately.

Decomposition:
- Shared package holds:
  - BRAN_WIDTH=3, with BRAN_NONE=0, BEQ=1, BNE=2, BLT=3, BGE=4, BLTU=5, BGEU=6.
  - JUMP_WIDTH=2, with JUMP_NONE=0, JAL=1, JALR=2.
  - FSM state encodings ST_RUN and ST_STALL.
- One natural combinational sub-module: bran_cmp, which takes (branch type, rs1, rs2) and returns taken.

Test Plan:
1. BEQ, ex_pc=0x100, imm=0x20, rs1=rs2=5, ex_valid=1 -> branch_en=1, redirect_pc=0x120 same cycle; flush_count 0→1. Repeat with ex_valid=0 -> branch_en=0, redirect_pc=0.
2. rs1=0xFFFFFFFF, rs2=1 -> BLT taken, BLTU not taken, BGEU taken; BNE with rs1=rs2=7 -> not taken.
3. JALR, rs1=0x1003, imm=4 -> jump_en=1, redirect_pc=0x1006. JAL, pc=0xFFFFFFF0, imm=0x20 -> redirect_pc=0x10 (wrap). jump+BEQ both set -> jump_en=1, branch_en=0.
4. LOAD_LAT=2: load with waddr=5, id rs1=5, uses_rs1=1 -> pipe_stall=1 and idu2exu_en=0 for exactly 2 cycles, then idu2exu_en=id_valid; stall_cycles=2. Same stimulus with waddr=0 or uses_rs1=0 -> no stall.
5. Hazard and jump asserted in the same cycle (forced) -> pipe_stall=0, jump_en=1, FSM stays RUN. Reset asserted mid-STALL -> pipe_stall=0 immediately, counters 0.
6. Force flush_count to 0xFFFFFFFE, then two redirects -> value 0xFFFFFFFF, holds (no wrap).

Source files
------------

// File: rtl/exu2idu_ctrl_pkg.sv
// Shared encodings for the EXU-to-IDU pipeline control slice: branch/jump
// type codes and the load-use stall FSM states.
package exu2idu_ctrl_pkg;

    localparam int BRAN_WIDTH = 3;
    localparam int JUMP_WIDTH = 2;
    localparam int STALL_CNT_WIDTH = 3;

    localparam logic [BRAN_WIDTH-1:0] BRAN_NONE = 3'd0;
    localparam logic [BRAN_WIDTH-1:0] BEQ       = 3'd1;
    localparam logic [BRAN_WIDTH-1:0] BNE       = 3'd2;
    localparam logic [BRAN_WIDTH-1:0] BLT       = 3'd3;
    localparam logic [BRAN_WIDTH-1:0] BGE       = 3'd4;
    localparam logic [BRAN_WIDTH-1:0] BLTU      = 3'd5;
    localparam logic [BRAN_WIDTH-1:0] BGEU      = 3'd6;

    localparam logic [JUMP_WIDTH-1:0] JUMP_NONE = 2'd0;
    localparam logic [JUMP_WIDTH-1:0] JAL       = 2'd1;
    localparam logic [JUMP_WIDTH-1:0] JALR      = 2'd2;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

endpackage

// File: rtl/exu2idu_ctrl_if.sv
// EX-stage fields, IDU hazard fields and the resulting pipeline control
// feedback, bundled between the pipeline and the control block.
interface exu2idu_ctrl_if #(
    parameter int CPU_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    import exu2idu_ctrl_pkg::*;

    logic                      ex_valid;
    logic [CPU_WIDTH-1:0]      ex_pc;
    logic [CPU_WIDTH-1:0]      ex_imm;
    logic [BRAN_WIDTH-1:0]     ex_branch;
    logic [JUMP_WIDTH-1:0]     ex_jump;
    logic [CPU_WIDTH-1:0]      ex_rs1_val;
    logic [CPU_WIDTH-1:0]      ex_rs2_val;
    logic                      ex_mem_ren;
    logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr;
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_reg1_raddr;
    logic [REG_ADDR_WIDTH-1:0] id_reg2_raddr;
    logic                      id_uses_rs1;
    logic                      id_uses_rs2;
    logic                      exu2idu_branch_en;
    logic                      exu2idu_jump_en;
    logic [CPU_WIDTH-1:0]      redirect_pc;
    logic                      idu2exu_en;
    logic                      pipe_stall;
    logic [CNT_WIDTH-1:0]      stall_cycles;
    logic [CNT_WIDTH-1:0]      flush_count;

    modport master (
        output ex_valid, ex_pc, ex_imm, ex_branch, ex_jump, ex_rs1_val, ex_rs2_val,
               ex_mem_ren, ex_reg_waddr, id_valid, id_reg1_raddr, id_reg2_raddr,
               id_uses_rs1, id_uses_rs2,
        input  exu2idu_branch_en, exu2idu_jump_en, redirect_pc, idu2exu_en,
               pipe_stall, stall_cycles, flush_count
    );

    modport slave (
        input  ex_valid, ex_pc, ex_imm, ex_branch, ex_jump, ex_rs1_val, ex_rs2_val,
               ex_mem_ren, ex_reg_waddr, id_valid, id_reg1_raddr, id_reg2_raddr,
               id_uses_rs1, id_uses_rs2,
        output exu2idu_branch_en, exu2idu_jump_en, redirect_pc, idu2exu_en,
               pipe_stall, stall_cycles, flush_count
    );

endinterface

// File: rtl/exu2idu_ctrl_bran_cmp.sv
// Branch condition evaluator: decides whether the EX-stage branch is taken
// from its type code and the forwarded operands.
module exu2idu_ctrl_bran_cmp
    import exu2idu_ctrl_pkg::*;
#(
    parameter int CPU_WIDTH = 32
) (
    input  logic [BRAN_WIDTH-1:0] branch,
    input  logic [CPU_WIDTH-1:0]  rs1,
    input  logic [CPU_WIDTH-1:0]  rs2,
    output logic                  taken
);

    // condition select; unused codes never take
    always_comb begin
        taken = 1'b0;
        case (branch)
            BRAN_NONE: taken = 1'b0;
            BEQ:       taken = (rs1 == rs2);
            BNE:       taken = (rs1 != rs2);
            BLT:       taken = ($signed(rs1) <  $signed(rs2));
            BGE:       taken = ($signed(rs1) >= $signed(rs2));
            BLTU:      taken = (rs1 <  rs2);
            BGEU:      taken = (rs1 >= rs2);
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/exu2idu_ctrl.sv
// EX-side pipeline control: zero-latency branch/jump redirect, load-use
// stall FSM and saturating stall/flush counters.
module exu2idu_ctrl
    import exu2idu_ctrl_pkg::*;
#(
    parameter int CPU_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LOAD_LAT       = 1,
    parameter int CNT_WIDTH      = 32
) (
    input logic          clk,
    input logic          rst_n,
    exu2idu_ctrl_if.slave bus
);

    localparam logic [STALL_CNT_WIDTH-1:0] LAT_M1     = STALL_CNT_WIDTH'(LOAD_LAT - 1);
    localparam logic [CPU_WIDTH-1:0]       ALIGN_MASK = {{(CPU_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [CNT_WIDTH-1:0]       CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                       taken_s;
    logic                       jump_en_s;
    logic                       branch_en_s;
    logic                       redirect_s;
    logic                       hazard_s;
    logic                       stall_s;
    logic [CPU_WIDTH-1:0]       redirect_pc_s;
    state_e                     state_r;
    state_e                     state_nxt_s;
    logic [STALL_CNT_WIDTH-1:0] cnt_r;
    logic [STALL_CNT_WIDTH-1:0] cnt_nxt_s;
    logic [CNT_WIDTH-1:0]       stall_cycles_r;
    logic [CNT_WIDTH-1:0]       flush_count_r;

    exu2idu_ctrl_bran_cmp #(.CPU_WIDTH(CPU_WIDTH)) u_bran_cmp (
        .branch (bus.ex_branch),
        .rs1    (bus.ex_rs1_val),
        .rs2    (bus.ex_rs2_val),
        .taken  (taken_s)
    );

    // redirect decision and target; jump has priority over a branch field
    always_comb begin
        jump_en_s   = bus.ex_valid & (bus.ex_jump != JUMP_NONE);
        branch_en_s = bus.ex_valid & (bus.ex_jump == JUMP_NONE) & taken_s;
        redirect_s  = jump_en_s | branch_en_s;
        if (jump_en_s && (bus.ex_jump == JALR)) begin
            redirect_pc_s = (bus.ex_rs1_val + bus.ex_imm) & ALIGN_MASK;
        end else if (redirect_s) begin
            redirect_pc_s = bus.ex_pc + bus.ex_imm;
        end else begin
            redirect_pc_s = '0;
        end
    end

    // load-use hazard against the instruction sitting in IDU
    always_comb begin
        hazard_s = bus.ex_valid & bus.ex_mem_ren & (bus.ex_reg_waddr != '0) & bus.id_valid &
                   ((bus.id_uses_rs1 & (bus.id_reg1_raddr == bus.ex_reg_waddr)) |
                    (bus.id_uses_rs2 & (bus.id_reg2_raddr == bus.ex_reg_waddr)));
    end

    // stall FSM next state; a redirect flushes the dependent instruction anyway
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        if (redirect_s) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (hazard_s) begin
                        stall_s = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nxt_s = ST_STALL;
                            cnt_nxt_s   = LAT_M1;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_STALL: begin
                    stall_s = 1'b1;
                    if (cnt_r == 3'd1) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = '0;
                end
            endcase
        end
    end

    // stall FSM state and remaining-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= '0;
            flush_count_r  <= '0;
        end else begin
            if (stall_s && (stall_cycles_r != '1)) begin
                stall_cycles_r <= stall_cycles_r + CNT_ONE;
            end
            if (redirect_s && (flush_count_r != '1)) begin
                flush_count_r <= flush_count_r + CNT_ONE;
            end
        end
    end

    assign bus.exu2idu_branch_en = branch_en_s;
    assign bus.exu2idu_jump_en   = jump_en_s;
    assign bus.redirect_pc       = redirect_pc_s;
    assign bus.pipe_stall        = stall_s;
    assign bus.idu2exu_en        = bus.id_valid & ~stall_s;
    assign bus.stall_cycles      = stall_cycles_r;
    assign bus.flush_count       = flush_count_r;

endmodule

// File: tb/tb_exu2idu_ctrl.sv
// Bench for exu2idu_ctrl: two instances (LOAD_LAT=2/32-bit counters and
// LOAD_LAT=1/3-bit counters) fed identical stimulus, checked against a model.
module tb_exu2idu_ctrl;
    import exu2idu_ctrl_pkg::*;

    localparam int CW = 32;
    localparam int RW = 5;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;
    localparam int CNT_A = 32;
    localparam int CNT_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          ex_valid, ex_mem_ren, id_valid, id_uses_rs1, id_uses_rs2;
    logic [CW-1:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
    logic [2:0]    ex_branch;
    logic [1:0]    ex_jump;
    logic [RW-1:0] ex_reg_waddr, id_reg1_raddr, id_reg2_raddr;

    exu2idu_ctrl_if #(.CPU_WIDTH(CW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CNT_A)) bus_a ();
    exu2idu_ctrl_if #(.CPU_WIDTH(CW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CNT_B)) bus_b ();

    assign bus_a.ex_valid      = ex_valid;      assign bus_b.ex_valid      = ex_valid;
    assign bus_a.ex_pc         = ex_pc;         assign bus_b.ex_pc         = ex_pc;
    assign bus_a.ex_imm        = ex_imm;        assign bus_b.ex_imm        = ex_imm;
    assign bus_a.ex_branch     = ex_branch;     assign bus_b.ex_branch     = ex_branch;
    assign bus_a.ex_jump       = ex_jump;       assign bus_b.ex_jump       = ex_jump;
    assign bus_a.ex_rs1_val    = ex_rs1_val;    assign bus_b.ex_rs1_val    = ex_rs1_val;
    assign bus_a.ex_rs2_val    = ex_rs2_val;    assign bus_b.ex_rs2_val    = ex_rs2_val;
    assign bus_a.ex_mem_ren    = ex_mem_ren;    assign bus_b.ex_mem_ren    = ex_mem_ren;
    assign bus_a.ex_reg_waddr  = ex_reg_waddr;  assign bus_b.ex_reg_waddr  = ex_reg_waddr;
    assign bus_a.id_valid      = id_valid;      assign bus_b.id_valid      = id_valid;
    assign bus_a.id_reg1_raddr = id_reg1_raddr; assign bus_b.id_reg1_raddr = id_reg1_raddr;
    assign bus_a.id_reg2_raddr = id_reg2_raddr; assign bus_b.id_reg2_raddr = id_reg2_raddr;
    assign bus_a.id_uses_rs1   = id_uses_rs1;   assign bus_b.id_uses_rs1   = id_uses_rs1;
    assign bus_a.id_uses_rs2   = id_uses_rs2;   assign bus_b.id_uses_rs2   = id_uses_rs2;

    exu2idu_ctrl #(.CPU_WIDTH(CW), .REG_ADDR_WIDTH(RW), .LOAD_LAT(LAT_A), .CNT_WIDTH(CNT_A))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    exu2idu_ctrl #(.CPU_WIDTH(CW), .REG_ADDR_WIDTH(RW), .LOAD_LAT(LAT_B), .CNT_WIDTH(CNT_B))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int n_total = 0;
    int n_bad = 0;

    // model state: stall cycles still owed after this one, and counter values
    int          left_a, left_b;
    logic [31:0] sc_a, fc_a;
    int          sc_b, fc_b;
    logic        m_br, m_jp, m_haz;
    logic [31:0] m_pc;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        left_a = 0; left_b = 0;
        sc_a = 32'd0; fc_a = 32'd0; sc_b = 0; fc_b = 0;
    endtask

    task automatic model_eval();
        logic t;
        case (ex_branch)
            3'd1:    t = (ex_rs1_val == ex_rs2_val);
            3'd2:    t = (ex_rs1_val != ex_rs2_val);
            3'd3:    t = ($signed(ex_rs1_val) <  $signed(ex_rs2_val));
            3'd4:    t = ($signed(ex_rs1_val) >= $signed(ex_rs2_val));
            3'd5:    t = (ex_rs1_val <  ex_rs2_val);
            3'd6:    t = (ex_rs1_val >= ex_rs2_val);
            default: t = 1'b0;
        endcase
        m_jp = ex_valid && (ex_jump != 2'd0);
        m_br = ex_valid && (ex_jump == 2'd0) && t;
        if (m_jp && ex_jump == 2'd2) m_pc = (ex_rs1_val + ex_imm) & 32'hFFFF_FFFE;
        else if (m_jp || m_br)       m_pc = ex_pc + ex_imm;
        else                         m_pc = 32'd0;
        m_haz = ex_valid && ex_mem_ren && (ex_reg_waddr != 5'd0) && id_valid &&
                ((id_uses_rs1 && id_reg1_raddr == ex_reg_waddr) ||
                 (id_uses_rs2 && id_reg2_raddr == ex_reg_waddr));
    endtask

    // one clock: compare everything at negedge, then advance the model at posedge
    task automatic cycle();
        logic st_a, st_b, redir;
        @(negedge clk);
        model_eval();
        redir = m_br || m_jp;
        st_a = !redir && (left_a > 0 || m_haz);
        st_b = !redir && (left_b > 0 || m_haz);
        check_val("br_a",    bus_a.exu2idu_branch_en, m_br);
        check_val("jp_a",    bus_a.exu2idu_jump_en,   m_jp);
        check_val("pc_a",    bus_a.redirect_pc,       m_pc);
        check_val("stall_a", bus_a.pipe_stall,        st_a);
        check_val("en_a",    bus_a.idu2exu_en,        id_valid && !st_a);
        check_val("sc_a",    bus_a.stall_cycles,      sc_a);
        check_val("fc_a",    bus_a.flush_count,       fc_a);
        check_val("br_b",    bus_b.exu2idu_branch_en, m_br);
        check_val("stall_b", bus_b.pipe_stall,        st_b);
        check_val("en_b",    bus_b.idu2exu_en,        id_valid && !st_b);
        check_val("sc_b",    bus_b.stall_cycles,      sc_b);
        check_val("fc_b",    bus_b.flush_count,       fc_b);
        @(posedge clk);
        if (redir)           left_a = 0;
        else if (left_a > 0) left_a--;
        else if (m_haz)      left_a = LAT_A - 1;
        if (redir)           left_b = 0;
        else if (left_b > 0) left_b--;
        else if (m_haz)      left_b = LAT_B - 1;
        if (st_a && sc_a != 32'hFFFF_FFFF) sc_a++;
        if (redir && fc_a != 32'hFFFF_FFFF) fc_a++;
        if (st_b && sc_b < 7) sc_b++;
        if (redir && fc_b < 7) fc_b++;
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_pc = 32'd0; ex_imm = 32'd0; ex_branch = 3'd0; ex_jump = 2'd0;
        ex_rs1_val = 32'd0; ex_rs2_val = 32'd0; ex_mem_ren = 1'b0; ex_reg_waddr = 5'd0;
        id_valid = 1'b0; id_reg1_raddr = 5'd0; id_reg2_raddr = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [2:0] br, input logic [1:0] jp,
                          input logic [31:0] a, input logic [31:0] b);
        ex_valid = v; ex_pc = pc; ex_imm = imm; ex_branch = br; ex_jump = jp;
        ex_rs1_val = a; ex_rs2_val = b;
        #1;
    endtask

    task automatic set_load_hazard(input logic [4:0] wa, input logic u1);
        idle();
        ex_valid = 1'b1; ex_mem_ren = 1'b1; ex_reg_waddr = wa;
        id_valid = 1'b1; id_reg1_raddr = 5'd5; id_uses_rs1 = u1;
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        do_reset();

        // reset state
        id_valid = 1'b1;
        #1;
        check_val("rst_stall", bus_a.pipe_stall, 1'b0);
        check_val("rst_en",    bus_a.idu2exu_en, 1'b1);
        check_val("rst_sc",    bus_a.stall_cycles, 32'd0);
        check_val("rst_fc",    bus_a.flush_count, 32'd0);
        cycle();

        // taken BEQ, then the same with ex_valid low
        set_ex(1'b1, 32'h100, 32'h20, BEQ, JUMP_NONE, 32'd5, 32'd5);
        check_val("t1_br", bus_a.exu2idu_branch_en, 1'b1);
        check_val("t1_pc", bus_a.redirect_pc, 32'h120);
        cycle();
        check_val("t1_fc", bus_a.flush_count, 32'd1);
        set_ex(1'b0, 32'h100, 32'h20, BEQ, JUMP_NONE, 32'd5, 32'd5);
        check_val("t1_br_inv", bus_a.exu2idu_branch_en, 1'b0);
        check_val("t1_pc_inv", bus_a.redirect_pc, 32'd0);
        cycle();

        // signed vs unsigned compares
        set_ex(1'b1, 32'h200, 32'h8, BLT, JUMP_NONE, 32'hFFFF_FFFF, 32'd1);
        check_val("t2_blt", bus_a.exu2idu_branch_en, 1'b1);
        cycle();
        set_ex(1'b1, 32'h200, 32'h8, BLTU, JUMP_NONE, 32'hFFFF_FFFF, 32'd1);
        check_val("t2_bltu", bus_a.exu2idu_branch_en, 1'b0);
        cycle();
        set_ex(1'b1, 32'h200, 32'h8, BGEU, JUMP_NONE, 32'hFFFF_FFFF, 32'd1);
        check_val("t2_bgeu", bus_a.exu2idu_branch_en, 1'b1);
        cycle();
        set_ex(1'b1, 32'h200, 32'h8, BNE, JUMP_NONE, 32'd7, 32'd7);
        check_val("t2_bne", bus_a.exu2idu_branch_en, 1'b0);
        cycle();

        // jumps: JALR alignment, JAL wrap, jump beats branch
        set_ex(1'b1, 32'h300, 32'd4, BRAN_NONE, JALR, 32'h1003, 32'd0);
        check_val("t3_jalr_en", bus_a.exu2idu_jump_en, 1'b1);
        check_val("t3_jalr_pc", bus_a.redirect_pc, 32'h1006);
        cycle();
        set_ex(1'b1, 32'hFFFF_FFF0, 32'h20, BRAN_NONE, JAL, 32'd0, 32'd0);
        check_val("t3_jal_pc", bus_a.redirect_pc, 32'h10);
        cycle();
        set_ex(1'b1, 32'h400, 32'h40, BEQ, JAL, 32'd1, 32'd1);
        check_val("t3_both_jp", bus_a.exu2idu_jump_en, 1'b1);
        check_val("t3_both_br", bus_a.exu2idu_branch_en, 1'b0);
        cycle();

        // load-use stall lasts LOAD_LAT cycles
        idle();
        cycle();
        set_load_hazard(5'd5, 1'b1);
        check_val("t4_stall0", bus_a.pipe_stall, 1'b1);
        check_val("t4_en0",    bus_a.idu2exu_en, 1'b0);
        cycle();
        ex_valid = 1'b0; ex_mem_ren = 1'b0;
        #1;
        check_val("t4_stall1", bus_a.pipe_stall, 1'b1);
        check_val("t4_en1",    bus_a.idu2exu_en, 1'b0);
        cycle();
        check_val("t4_stall2", bus_a.pipe_stall, 1'b0);
        check_val("t4_en2",    bus_a.idu2exu_en, 1'b1);
        check_val("t4_sc",     bus_a.stall_cycles, 32'd2);
        cycle();
        set_load_hazard(5'd0, 1'b1);
        check_val("t4_x0", bus_a.pipe_stall, 1'b0);
        cycle();
        set_load_hazard(5'd5, 1'b0);
        check_val("t4_nouse", bus_a.pipe_stall, 1'b0);
        cycle();

        // hazard with a simultaneous jump: redirect wins
        set_load_hazard(5'd5, 1'b1);
        ex_jump = JAL; ex_imm = 32'h80;
        #1;
        check_val("t5_stall", bus_a.pipe_stall, 1'b0);
        check_val("t5_jp",    bus_a.exu2idu_jump_en, 1'b1);
        cycle();
        ex_valid = 1'b0; ex_jump = JUMP_NONE;
        #1;
        check_val("t5_run", bus_a.pipe_stall, 1'b0);
        cycle();

        // asynchronous reset while in STALL
        set_load_hazard(5'd5, 1'b1);
        cycle();
        ex_valid = 1'b0;
        #1;
        check_val("t5_in_stall", bus_a.pipe_stall, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_stall", bus_a.pipe_stall, 1'b0);
        check_val("t5_rst_sc",    bus_a.stall_cycles, 32'd0);
        check_val("t5_rst_fc",    bus_a.flush_count, 32'd0);
        do_reset();

        // flush counter saturation on the narrow-counter instance
        for (int i = 0; i < 9; i++) begin
            set_ex(1'b1, 32'h500, 32'h4, BRAN_NONE, JAL, 32'd0, 32'd0);
            cycle();
        end
        check_val("t6_fc_sat", bus_b.flush_count, 3'd7);
        check_val("t6_fc_a",   bus_a.flush_count, 32'd9);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pool [5];
            pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFF_FFFF;
            pool[3] = 32'h8000_0000; pool[4] = $urandom;
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_pc         = $urandom;
            ex_imm        = $urandom;
            ex_jump       = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            ex_branch     = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            ex_rs1_val    = pool[$urandom_range(0, 4)];
            ex_rs2_val    = ($urandom_range(0, 3) == 0) ? ex_rs1_val : pool[$urandom_range(0, 4)];
            ex_mem_ren    = $urandom_range(0, 1) == 1;
            ex_reg_waddr  = 5'($urandom_range(0, 3));
            id_valid      = ($urandom_range(0, 3) != 0);
            id_reg1_raddr = 5'($urandom_range(0, 3));
            id_reg2_raddr = 5'($urandom_range(0, 3));
            id_uses_rs1   = $urandom_range(0, 1) == 1;
            id_uses_rs2   = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
